// File: rtl/divider32_if.sv
// divider32_if: start/busy/done handshake and operand/result bus of the
// 32-bit iterative divider. The master is the issue logic (or a bench),
// the slave is the divider itself.
interface divider32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dz;

    modport master (
        output start, opa, opb,
        input  busy, done, quo, rem, dz
    );

    modport slave (
        input  start, opa, opb,
        output busy, done, quo, rem, dz
    );
endinterface

// File: rtl/divider32.sv
// divider32: unsigned restoring divider, one trial subtraction per clock.
// A start accepted in IDLE runs 32 steps in RUN, then DONE pulses for one
// cycle with quo/rem/dz loaded. Results hold until the next completion.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips RUN and completes
// straight from IDLE with quo=all ones, rem=dividend, dz=1.
module divider32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    divider32_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] dvd_q,   dvd_d;   // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr_q,   dsr_d;   // divisor, stable for the whole op
    logic [WIDTH-1:0] pr_q,    pr_d;    // partial remainder
    logic [WIDTH-1:0] quo_q,   quo_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic             dz_q,    dz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] pr_step;
    logic [WIDTH-1:0] dvd_step;

    // One restoring step: shift in the next dividend bit, try the subtract,
    // keep it only when it does not borrow.
    always_comb begin
        trial    = {pr_q, dvd_q[WIDTH-1]};
        diff     = trial - {1'b0, dsr_q};
        qbit     = ~diff[WIDTH];
        pr_step  = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_step = {dvd_q[WIDTH-2:0], qbit};
    end

    // Control FSM and datapath next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        pr_d    = pr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dvd_d   = bus.opa;
                    dsr_d   = bus.opb;
                    pr_d    = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.opb == '0) begin
                        quo_d   = '1;
                        rem_d   = bus.opa;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                dvd_d = dvd_step;
                pr_d  = pr_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    quo_d   = dvd_step;
                    rem_d   = pr_step;
                    dz_d    = (dsr_q == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any op in flight and clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            pr_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            pr_q    <= pr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.quo  = quo_q;
    assign bus.rem  = rem_q;
    assign bus.dz   = dz_q;

endmodule

// File: doc/divider32.md
Name: divider32

Overview:
- 32-bit unsigned iterative restoring divider: the subtract-side counterpart of the team's 32-bit adder.
- Produces quotient and remainder with one trial subtraction per clock.
- Start/busy/done handshake for use by the ALU issue logic as a multi-cycle functional unit beside the single-cycle adder.

Parameters:
WIDTH, 32, operand/result width (only 32 is verified)
CNT_W, 5, iteration counter width, equal to log2(WIDTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
opa  input  32  dividend; sampled with accepted start
opb  input  32  divisor; sampled with accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, results valid
quo  output  32  quotient, registered
rem  output  32  remainder, registered
dz  output  1  divide-by-zero flag for the last completed op

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (async, any state): state=IDLE; cnt=0; busy=0, done=0, quo=0, rem=0, dz=0; internal dividend, divisor and partial-remainder registers=0.
- Reset mid-operation aborts the op; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 latches opa into the dividend shift register and opb into the divisor register.
  - Partial remainder is cleared, cnt=0, state goes to RUN.
  - start=0: remain in IDLE.
- RUN, one restoring step per edge:
  - t = {pr[31:0], dvd[31]} (33 bits); d = t - {1'b0, divisor} (33-bit subtract).
  - d[32]=0: pr=d[31:0], shift 1 into dvd LSB.
  - Otherwise: pr=t[31:0], shift 0 into dvd LSB.
  - dvd shifts left one place each step; after 32 steps dvd holds the quotient and pr the remainder.
  - cnt increments each step. The step with cnt==31 (edge E32) also loads quo, rem and dz (dz=1 iff divisor==0) and moves to DONE.
- DONE: lasts one cycle with done=1; next edge goes to IDLE.
- Latency: done is high in the cycle after E32, i.e. 32 cycles after start acceptance. Throughput is one op per 34 cycles.
- busy=1 exactly in RUN; busy and done are never high together.
- start while in RUN or DONE is ignored, not queued. A new op is accepted only on an IDLE-cycle edge.
- quo, rem and dz hold their values until the next completion or reset; they do not change during RUN.
- Divide by zero: the natural restoring result is produced, quo=32'hFFFFFFFF and rem=opa, with dz=1.
- opa/opb changes after acceptance have no effect.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined, start in IDLE with opb==0:
  - Skip RUN. At E0 load quo=32'hFFFFFFFF, rem=opa, dz=1 and go to DONE.
  - done is high in the cycle after E0; busy stays 0.
  - Nonzero divisors are unaffected.
- Undefined: divide by zero takes the full 32-step path with the identical result and 32-cycle latency.

Test Plan:
- opa=100, opb=7, start one cycle -> busy for 32 cycles, then done pulse; quo=14, rem=2, dz=0; outputs hold afterwards.
- opa=32'hFFFFFFFF, opb=1 -> quo=32'hFFFFFFFF, rem=0. Then opa=32'hFFFFFFFF, opb=32'hFFFFFFFF -> quo=1, rem=0.
- opa=3, opb=10 -> quo=0, rem=3. Back-to-back: start held high continuously -> second op accepted in the IDLE cycle after done; done pulses spaced 34 cycles apart.
- opa=5, opb=0 -> quo=32'hFFFFFFFF, rem=5, dz=1.
  - Without DIV_ZERO_FAST_EN: done after 32 cycles.
  - With it: done in the cycle after acceptance, busy never high.
- start pulsed with opa=50, opb=9 at RUN cycle 10 of the op 100/7 -> ignored; result quo=14, rem=2; only one done.
- rst_n low at RUN cycle 15 -> all outputs 0 immediately (asynchronous); no done; a new op 81/9 afterwards -> quo=9, rem=0.
